// File: rtl/adder_arbiter_pkg.sv
// Purpose : shared types and helpers for the time-shared adder and other round-robin arbiters.
// Latency : n/a (declarations only).
// Backpressure: n/a.
package adder_arb_pkg;

    localparam int N_REQ_DEF = 3;
    localparam int WIDTH_DEF = 64;

    // State of the single-entry result register.
    typedef enum logic {
        RES_EMPTY = 1'b0,
        RES_FULL  = 1'b1
    } res_state_e;

    // Round-robin pointer increment.
    // Wraps at n, not at the next power of two, so the pointer never names a nonexistent requester.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Purpose : bundles the requester-side and consumer-side signals of the shared adder.
// Latency : n/a (wiring only).
// Backpressure: req_ready grants one requester per cycle; res_ready drains the result register.
// Ports   : req_valid/req_a/req_b/req_ready form the request side, with operands packed per requester.
//           res_valid/res_data/res_carry/res_id/res_ready form the result side.
//           The master modport is the requester/consumer environment; the slave modport is the arbiter.
interface adder_arbiter_if
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) ();

    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_a;
    logic [N_REQ*WIDTH-1:0] req_b;
    logic [N_REQ-1:0]       req_ready;
    logic                   res_valid;
    logic [WIDTH-1:0]       res_data;
    logic                   res_carry;
    logic [ID_W-1:0]        res_id;
    logic                   res_ready;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_data, res_carry, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_data, res_carry, res_id
    );

endinterface

// File: rtl/adder_arbiter_rr_picker.sv
// Purpose : round-robin picker that selects the first valid requester at or after ptr, wrapping at N_REQ.
// Latency : purely combinational.
// Backpressure: none; the caller qualifies the grant with its own accept condition.
// Ports   : i_valid (per-requester request), i_ptr (highest-priority index),
//           o_grant (one-hot), o_grant_idx (binary index), o_any (some requester valid).
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]  i_ptr,
    output logic [N_REQ-1:0] o_grant,
    output logic [ID_W-1:0]  o_grant_idx,
    output logic             o_any
);

    // One extra bit so that ptr+k can be compared against N_REQ before wrapping.
    logic [ID_W:0] w_pos;

    always_comb begin
        o_any       = 1'b0;
        o_grant_idx = '0;
        w_pos       = '0;
        // Walk the search order from last to first, so the final hit is the
        // requester closest to ptr.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_ptr} + (ID_W+1)'(k);
            if (w_pos >= (ID_W+1)'(N_REQ)) begin
                w_pos = w_pos - (ID_W+1)'(N_REQ);
            end
            if (i_valid[w_pos[ID_W-1:0]]) begin
                o_any       = 1'b1;
                o_grant_idx = w_pos[ID_W-1:0];
            end
        end
    end

    always_comb begin
        o_grant = '0;
        for (int i = 0; i < N_REQ; i++) begin
            o_grant[i] = o_any & (o_grant_idx == ID_W'(i));
        end
    end

endmodule

// File: rtl/adder_arbiter.sv
// Purpose : one WIDTH-bit adder time-shared by N_REQ requesters under round-robin arbitration.
// Latency : 1 cycle from the transfer edge to res_*; throughput is 1 result per cycle.
// Backpressure: a grant is issued only while the result register is empty or draining (res_ready).
// Ports   : clk, reset_n (synchronous, active-low); bus (slave modport) carries the requests and the result.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic            clk,
    input  logic            reset_n,
    adder_arbiter_if.slave  bus
);

    res_state_e        r_state;
    res_state_e        w_state_nxt;
    logic [ID_W-1:0]   r_ptr;
    logic [WIDTH-1:0]  r_data;
    logic              r_carry;
    logic [ID_W-1:0]   r_id;

    logic [N_REQ-1:0]  w_grant;
    logic [ID_W-1:0]   w_grant_idx;
    logic              w_any;
    logic              w_accept;
    logic              w_xfer;
    logic [WIDTH-1:0]  w_a;
    logic [WIDTH-1:0]  w_b;
    logic [WIDTH:0]    w_sum;

    rr_picker #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_picker (
        .i_valid     (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    // The register can take a new result when it is empty or being drained this cycle.
    // reset_n gates the grant so that no transfer is recorded in a reset cycle.
    assign w_accept = (r_state == RES_EMPTY) | bus.res_ready;
    assign w_xfer   = reset_n & w_accept & w_any;

    assign bus.req_ready = w_xfer ? w_grant : '0;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_grant[i]) begin
                w_a = bus.req_a[i*WIDTH +: WIDTH];
                w_b = bus.req_b[i*WIDTH +: WIDTH];
            end
        end
    end

    // Widened by one bit so the carry-out comes from the same add.
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= RES_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RES_EMPTY: begin
                if (w_xfer) begin
                    w_state_nxt = RES_FULL;
                end
            end
            RES_FULL: begin
                if (w_xfer) begin
                    w_state_nxt = RES_FULL;
                end else if (bus.res_ready) begin
                    w_state_nxt = RES_EMPTY;
                end
            end
            default: w_state_nxt = RES_EMPTY;
        endcase
    end

    // Payload and pointer move only on a transfer, so a stalled winner keeps its priority.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_carry <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_data  <= w_sum[WIDTH-1:0];
            r_carry <= w_sum[WIDTH];
            r_id    <= w_grant_idx;
            r_ptr   <= ID_W'(rr_next(32'(w_grant_idx), N_REQ));
        end
    end

    assign bus.res_valid = (r_state == RES_FULL);
    assign bus.res_data  = r_data;
    assign bus.res_carry = r_carry;
    assign bus.res_id    = r_id;

endmodule
